// File: rtl/lvdc_timing_pkg.sv
// Shared types and width helpers for the LVDC timing generator.
// Every counter field is at least one bit wide, including SYL when SYLLABLES=1.
package lvdc_timing_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_HALT = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_HALTED,
    ST_RUN,
    ST_DRAIN,
    ST_STEPPING
  } fsm_t;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int bt_w(input int bit_times);
    return cnt_w(bit_times);
  endfunction

  function automatic int ph_w(input int phases);
    return cnt_w(phases);
  endfunction

  function automatic int syl_w(input int syllables);
    return cnt_w(syllables);
  endfunction

endpackage

// File: rtl/lvdc_timing_chan.sv
// One redundant bit-time/phase/syllable counter channel.
// A channel that disagrees with the vote rebuilds its next value from the vote.
module lvdc_timing_chan
  import lvdc_timing_pkg::*;
#(
  parameter int BIT_TIMES = 28,
  parameter int PHASES    = 4,
  parameter int SYLLABLES = 2,
  localparam int BT_W  = bt_w(BIT_TIMES),
  localparam int PH_W  = ph_w(PHASES),
  localparam int SYL_W = syl_w(SYLLABLES)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             adv_i,
  input  logic             load_i,
  input  logic             fault_i,
  input  logic [BT_W-1:0]  vote_bt_i,
  input  logic [PH_W-1:0]  vote_ph_i,
  input  logic [SYL_W-1:0] vote_syl_i,
  output logic [BT_W-1:0]  bt_o,
  output logic [PH_W-1:0]  ph_o,
  output logic [SYL_W-1:0] syl_o
);

  localparam logic [BT_W-1:0]  BT_MAX  = BT_W'(BIT_TIMES - 1);
  localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(PHASES - 1);
  localparam logic [SYL_W-1:0] SYL_MAX = SYL_W'(SYLLABLES - 1);

  logic [BT_W-1:0]  bt_q, bt_d, base_bt;
  logic [PH_W-1:0]  ph_q, ph_d, base_ph;
  logic [SYL_W-1:0] syl_q, syl_d, base_syl;

  always_comb begin
    base_bt  = load_i ? vote_bt_i  : bt_q;
    base_ph  = load_i ? vote_ph_i  : ph_q;
    base_syl = load_i ? vote_syl_i : syl_q;
    bt_d     = base_bt;
    ph_d     = base_ph;
    syl_d    = base_syl;
    if (adv_i) begin
      if (base_bt == BT_MAX) begin
        bt_d = '0;
        if (base_ph == PH_MAX) begin
          ph_d = '0;
          // SYL_MAX is 0 for a single syllable, so SYL holds at 0
          syl_d = (base_syl == SYL_MAX) ? '0 : base_syl + SYL_W'(1);
        end else begin
          ph_d = base_ph + PH_W'(1);
        end
      end else begin
        bt_d = base_bt + BT_W'(1);
      end
    end
    bt_d[0] = bt_d[0] ^ fault_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bt_q  <= '0;
      ph_q  <= '0;
      syl_q <= '0;
    end else begin
      bt_q  <= bt_d;
      ph_q  <= ph_d;
      syl_q <= syl_d;
    end
  end

  assign bt_o  = bt_q;
  assign ph_o  = ph_q;
  assign syl_o = syl_q;

endmodule

// File: rtl/lvdc_timing_gen.sv
// LVDC bit-time/phase/syllable generator with optional TMR voting and HALT/STEP control.
// state       | meaning
// ST_HALTED   | counters frozen on a phase boundary (BT=0)
// ST_RUN      | free running
// ST_DRAIN    | halt requested, finishing the current phase
// ST_STEPPING | executing one phase for a STEP pulse
module lvdc_timing_gen
  import lvdc_timing_pkg::*;
#(
  parameter int BIT_TIMES = 28,
  parameter int PHASES    = 4,
  parameter int SYLLABLES = 2,
  parameter int CHANNELS  = 3,
  localparam int BT_W  = bt_w(BIT_TIMES),
  localparam int PH_W  = ph_w(PHASES),
  localparam int SYL_W = syl_w(SYLLABLES)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [1:0]          mode_i,
  input  logic                step_i,
  input  logic [CHANNELS-1:0] fault_inj_i,
  input  logic                err_clr_i,
  output logic [BT_W-1:0]     bt_o,
  output logic [PH_W-1:0]     ph_o,
  output logic [SYL_W-1:0]    syl_o,
  output logic                phase_end_o,
  output logic                word_end_o,
  output logic                running_o,
  output logic                miscmp_o,
  output logic [CHANNELS-1:0] err_o
);

  localparam logic [BT_W-1:0] BT_MAX = BT_W'(BIT_TIMES - 1);
  localparam logic [PH_W-1:0] PH_MAX = PH_W'(PHASES - 1);

  fsm_t  state_q, state_d;
  mode_t mode;
  logic  adv;
  logic  phase_end;

  logic [BT_W-1:0]  ch_bt  [CHANNELS];
  logic [PH_W-1:0]  ch_ph  [CHANNELS];
  logic [SYL_W-1:0] ch_syl [CHANNELS];
  logic [BT_W-1:0]  vote_bt;
  logic [PH_W-1:0]  vote_ph;
  logic [SYL_W-1:0] vote_syl;
  logic [CHANNELS-1:0] ch_mis;
  logic [CHANNELS-1:0] err_q, err_d;

  assign mode      = mode_t'(mode_i);
  assign adv       = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_STEPPING);
  assign phase_end = adv && (vote_bt == BT_MAX);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    lvdc_timing_chan #(
      .BIT_TIMES(BIT_TIMES),
      .PHASES   (PHASES),
      .SYLLABLES(SYLLABLES)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .adv_i     (adv),
      .load_i    (ch_mis[g]),
      .fault_i   (fault_inj_i[g]),
      .vote_bt_i (vote_bt),
      .vote_ph_i (vote_ph),
      .vote_syl_i(vote_syl),
      .bt_o      (ch_bt[g]),
      .ph_o      (ch_ph[g]),
      .syl_o     (ch_syl[g])
    );
  end

  if (CHANNELS == 3) begin : g_tmr
    assign vote_bt  = (ch_bt[0] & ch_bt[1]) | (ch_bt[0] & ch_bt[2]) | (ch_bt[1] & ch_bt[2]);
    assign vote_ph  = (ch_ph[0] & ch_ph[1]) | (ch_ph[0] & ch_ph[2]) | (ch_ph[1] & ch_ph[2]);
    assign vote_syl = (ch_syl[0] & ch_syl[1]) | (ch_syl[0] & ch_syl[2]) | (ch_syl[1] & ch_syl[2]);
    for (genvar g = 0; g < 3; g++) begin : g_cmp
      assign ch_mis[g] = (ch_bt[g] != vote_bt) || (ch_ph[g] != vote_ph) || (ch_syl[g] != vote_syl);
    end
  end else begin : g_simplex
    assign vote_bt  = ch_bt[0];
    assign vote_ph  = ch_ph[0];
    assign vote_syl = ch_syl[0];
    assign ch_mis   = '0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HALTED: begin
        if (mode == MODE_RUN)                state_d = ST_RUN;
        else if (mode == MODE_STEP && step_i) state_d = ST_STEPPING;
      end
      ST_RUN: begin
        if (mode != MODE_RUN) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (mode == MODE_RUN) state_d = ST_RUN;
        else if (phase_end)   state_d = ST_HALTED;
      end
      ST_STEPPING: begin
        if (phase_end) state_d = ST_HALTED;
      end
      default: state_d = ST_HALTED;
    endcase
  end

  // clear wins over a disagreement seen in the same cycle
  assign err_d = err_clr_i ? '0 : (err_q | ch_mis);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_HALTED;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign bt_o        = vote_bt;
  assign ph_o        = vote_ph;
  assign syl_o       = vote_syl;
  assign phase_end_o = phase_end;
  assign word_end_o  = phase_end && (vote_ph == PH_MAX);
  assign running_o   = adv;
  assign miscmp_o    = |ch_mis;
  assign err_o       = err_q;

endmodule

// File: tb/tb_lvdc_timing_gen.sv
// Directed bench: a default TMR instance (28/4/2/3) and a small simplex instance (3/2/1/1).
module tb_lvdc_timing_gen;

  logic clk;
  logic rst_n;

  logic [1:0] mode;
  logic       step;
  logic [2:0] fault;
  logic       err_clr;
  logic [4:0] bt;
  logic [1:0] ph;
  logic [0:0] syl;
  logic       pe, we, running, miscmp;
  logic [2:0] err;

  logic [1:0] mode_s;
  logic       step_s;
  logic [0:0] fault_s;
  logic       err_clr_s;
  logic [1:0] bt_s;
  logic [0:0] ph_s;
  logic [0:0] syl_s;
  logic       pe_s, we_s, running_s, miscmp_s;
  logic [0:0] err_s;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [1:0] mode;
    logic       step;
    logic       fault;
    int         bt;
    int         ph;
    int         pe;
    int         we;
    int         run;
  } vec_t;

  vec_t tbl[19];

  lvdc_timing_gen dut (
    .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode), .step_i(step),
    .fault_inj_i(fault), .err_clr_i(err_clr),
    .bt_o(bt), .ph_o(ph), .syl_o(syl), .phase_end_o(pe), .word_end_o(we),
    .running_o(running), .miscmp_o(miscmp), .err_o(err)
  );

  lvdc_timing_gen #(.BIT_TIMES(3), .PHASES(2), .SYLLABLES(1), .CHANNELS(1)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode_s), .step_i(step_s),
    .fault_inj_i(fault_s), .err_clr_i(err_clr_s),
    .bt_o(bt_s), .ph_o(ph_s), .syl_o(syl_s), .phase_end_o(pe_s), .word_end_o(we_s),
    .running_o(running_s), .miscmp_o(miscmp_s), .err_o(err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    mode = 2'b01; step = 1'b0; fault = 3'b000; err_clr = 1'b0;
    mode_s = 2'b01; step_s = 1'b0; fault_s = 1'b0; err_clr_s = 1'b0;

    // mode, step, fault | bt, ph, phase_end, word_end, running
    tbl[0]  = '{2'b00, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    tbl[1]  = '{2'b00, 1'b0, 1'b0, 0, 0, 0, 0, 1};
    tbl[2]  = '{2'b00, 1'b0, 1'b0, 1, 0, 0, 0, 1};
    tbl[3]  = '{2'b00, 1'b0, 1'b0, 2, 0, 1, 0, 1};
    tbl[4]  = '{2'b00, 1'b0, 1'b0, 0, 1, 0, 0, 1};
    tbl[5]  = '{2'b00, 1'b0, 1'b0, 1, 1, 0, 0, 1};
    tbl[6]  = '{2'b00, 1'b0, 1'b0, 2, 1, 1, 1, 1};
    tbl[7]  = '{2'b01, 1'b0, 1'b0, 0, 0, 0, 0, 1};
    tbl[8]  = '{2'b01, 1'b0, 1'b0, 1, 0, 0, 0, 1};
    tbl[9]  = '{2'b01, 1'b0, 1'b0, 2, 0, 1, 0, 1};
    tbl[10] = '{2'b10, 1'b1, 1'b0, 0, 1, 0, 0, 0};
    tbl[11] = '{2'b10, 1'b1, 1'b0, 0, 1, 0, 0, 1};
    tbl[12] = '{2'b10, 1'b0, 1'b0, 1, 1, 0, 0, 1};
    tbl[13] = '{2'b10, 1'b0, 1'b0, 2, 1, 1, 1, 1};
    tbl[14] = '{2'b10, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    tbl[15] = '{2'b11, 1'b1, 1'b0, 0, 0, 0, 0, 0};
    tbl[16] = '{2'b01, 1'b0, 1'b1, 0, 0, 0, 0, 0};
    tbl[17] = '{2'b01, 1'b0, 1'b0, 1, 0, 0, 0, 0};
    tbl[18] = '{2'b01, 1'b0, 1'b0, 1, 0, 0, 0, 0};

    #3;
    chk("rst_bt", bt, 0);
    chk("rst_ph", ph, 0);
    chk("rst_syl", syl, 0);
    chk("rst_pe", pe, 0);
    chk("rst_we", we, 0);
    chk("rst_running", running, 0);
    chk("rst_miscmp", miscmp, 0);
    chk("rst_err", err, 0);
    chk("rst_s_bt", bt_s, 0);
    chk("rst_s_running", running_s, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // small simplex instance: wrap sequence, drain, step, mode 11, uncorrected fault
    for (int i = 0; i < 19; i++) begin
      mode_s  = tbl[i].mode;
      step_s  = tbl[i].step;
      fault_s = tbl[i].fault;
      #1;
      chk($sformatf("s%0d_bt", i), bt_s, tbl[i].bt);
      chk($sformatf("s%0d_ph", i), ph_s, tbl[i].ph);
      chk($sformatf("s%0d_syl", i), syl_s, 0);
      chk($sformatf("s%0d_pe", i), pe_s, tbl[i].pe);
      chk($sformatf("s%0d_we", i), we_s, tbl[i].we);
      chk($sformatf("s%0d_run", i), running_s, tbl[i].run);
      chk($sformatf("s%0d_miscmp", i), miscmp_s, 0);
      chk($sformatf("s%0d_err", i), err_s, 0);
      tick();
    end
    fault_s = 1'b0;

    // default instance: RUN from reset, then HALT at BT=10 of the fifth phase
    chk("pre_run_bt", bt, 0);
    chk("pre_run_running", running, 0);
    mode = 2'b00;
    tick();
    for (int i = 0; i < 140; i++) begin
      if (i == 122) mode = 2'b01;
      #1;
      chk($sformatf("run%0d_bt", i), bt, i % 28);
      chk($sformatf("run%0d_ph", i), ph, (i / 28) % 4);
      chk($sformatf("run%0d_syl", i), syl, (i / 112) % 2);
      chk($sformatf("run%0d_pe", i), pe, (i % 28) == 27);
      chk($sformatf("run%0d_we", i), we, ((i % 28) == 27) && (((i / 28) % 4) == 3));
      chk($sformatf("run%0d_running", i), running, 1);
      tick();
    end
    chk("halt_bt", bt, 0);
    chk("halt_ph", ph, 1);
    chk("halt_syl", syl, 1);
    chk("halt_running", running, 0);
    tick();
    chk("halt_hold_bt", bt, 0);
    chk("halt_hold_running", running, 0);

    // single STEP: one phase of advances; a second pulse mid-step is ignored
    mode = 2'b10;
    step = 1'b1;
    #1;
    chk("step_pre_running", running, 0);
    tick();
    step = 1'b0;
    for (int j = 0; j < 28; j++) begin
      step = (j == 13);
      #1;
      chk($sformatf("step%0d_running", j), running, 1);
      chk($sformatf("step%0d_bt", j), bt, j);
      chk($sformatf("step%0d_ph", j), ph, 1);
      tick();
    end
    step = 1'b0;
    chk("step_done_running", running, 0);
    chk("step_done_bt", bt, 0);
    chk("step_done_ph", ph, 2);
    tick();
    chk("step_hold_running", running, 0);
    chk("step_hold_bt", bt, 0);

    // single-channel fault: vote holds, channel resyncs, ERR sticky until cleared
    mode = 2'b00;
    tick();
    repeat (5) tick();
    chk("flt_pre_bt", bt, 5);
    fault = 3'b010;
    tick();
    fault = 3'b000;
    chk("flt1_bt", bt, 6);
    chk("flt1_miscmp", miscmp, 1);
    chk("flt1_err", err, 0);
    tick();
    chk("flt2_bt", bt, 7);
    chk("flt2_miscmp", miscmp, 0);
    chk("flt2_err", err, 3'b010);
    tick();
    chk("flt3_bt", bt, 8);
    chk("flt3_err", err, 3'b010);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_bt", bt, 9);
    chk("clr_err", err, 0);

    // double fault: vote follows the corrupted pair, clear beats same-cycle set
    fault = 3'b110;
    tick();
    fault = 3'b000;
    chk("dbl1_bt", bt, 11);
    chk("dbl1_miscmp", miscmp, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("dbl1_clr_err", err, 0);
    chk("dbl1_resync_bt", bt, 12);
    chk("dbl1_resync_miscmp", miscmp, 0);
    fault = 3'b110;
    tick();
    fault = 3'b000;
    chk("dbl2_bt", bt, 12);
    chk("dbl2_miscmp", miscmp, 1);
    chk("dbl2_err", err, 0);
    tick();
    chk("dbl2_next_bt", bt, 13);
    chk("dbl2_next_err", err, 3'b001);
    chk("dbl2_next_miscmp", miscmp, 0);

    // halt, then reset in the middle of a STEP
    mode = 2'b01;
    begin : wait_halt
      int k;
      k = 0;
      while (running && k < 200) begin
        tick();
        k++;
      end
      chk("drain_timeout", k < 200, 1);
    end
    chk("drain_bt", bt, 0);
    mode = 2'b10;
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (14) tick();
    chk("mid_step_bt", bt, 14);
    chk("mid_step_running", running, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_bt", bt, 0);
    chk("async_rst_ph", ph, 0);
    chk("async_rst_syl", syl, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_pe", pe, 0);
    chk("async_rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_running", running, 0);
    chk("post_rst_bt", bt, 0);
    tick();
    chk("post_rst_hold_running", running, 0);
    chk("post_rst_hold_bt", bt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
